// File: rtl/round_timer_pkg.sv
// Shared types and helpers for the round countdown controller.
package round_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_STOPPED,
    ST_EXPIRED
  } state_e;

  // Clock cycles per countdown tick.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int presc_width(input int div);
    return $clog2(div);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: counts 0..DIV-1 while enabled; wrap_o flags the
// terminal count so the owner can decide whether this edge is a tick.
module tick_prescaler
  import round_timer_pkg::*;
#(
  parameter int DIV   = 10,
  parameter int CNT_W = presc_width(DIV)
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == LAST);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/round_timer_ctrl.sv
// Per-round seconds countdown with start, pause/resume, player stop and
// timeout; all status outputs are registered.
module round_timer_ctrl
  import round_timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int SEC_W   = 7
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [SEC_W-1:0] load_secs,
  output logic [SEC_W-1:0] secs_left,
  output logic             tick,
  output logic             running,
  output logic             paused,
  output logic             stopped,
  output logic             expired
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

  state_e           state_q, state_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic             tick_q, tick_d;
  logic             running_q, paused_q, stopped_q, expired_q;
  logic             presc_clr, presc_en, at_last;

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clk_in (clk_in),
    .rst    (rst),
    .clr_i  (presc_clr),
    .en_i   (presc_en),
    .wrap_o (at_last)
  );

  always_comb begin
    state_d   = state_q;
    secs_d    = secs_q;
    tick_d    = 1'b0;
    presc_clr = 1'b0;
    presc_en  = 1'b0;

    if (start) begin
      presc_clr = 1'b1;
      if (load_secs != '0) begin
        state_d = ST_RUN;
        secs_d  = load_secs;
      end else begin
        state_d = ST_EXPIRED;
        secs_d  = '0;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (stop) begin
            state_d = ST_STOPPED;
          end else if (pause) begin
            // Hold at the terminal count so a pause never swallows a second.
            state_d  = ST_PAUSE;
            presc_en = !at_last;
          end else begin
            presc_en = 1'b1;
            if (at_last && secs_q != '0) begin
              tick_d = 1'b1;
              secs_d = secs_q - 1'b1;
              if (secs_q == SEC_W'(1)) state_d = ST_EXPIRED;
            end
          end
        end
        ST_PAUSE: begin
          if (stop)       state_d = ST_STOPPED;
          else if (pause) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      secs_q    <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      stopped_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      secs_q    <= secs_d;
      tick_q    <= tick_d;
      running_q <= (state_d == ST_RUN);
      paused_q  <= (state_d == ST_PAUSE);
      stopped_q <= (state_d == ST_STOPPED);
      expired_q <= (state_d == ST_EXPIRED);
    end
  end

  assign secs_left = secs_q;
  assign tick      = tick_q;
  assign running   = running_q;
  assign paused    = paused_q;
  assign stopped   = stopped_q;
  assign expired   = expired_q;

endmodule

// File: doc/round_timer_ctrl.md
Name: round_timer_ctrl

Overview:
Countdown controller for one game round. It owns a clock-enable prescaler that turns clk_in into a one-cycle tick at TICK_HZ; it never generates a derived clock. It sequences a per-round seconds countdown with start, pause/resume, player-stop and timeout. It sits between the game FSM (start/stop/pause requests) and the display/scoring logic, which consumes secs_left and the status flags.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
TICK_HZ, 1, countdown tick rate in Hz; DIV = CLK_HZ/TICK_HZ, must be an integer >= 2
SEC_W, 7, width of the seconds count (0..127)

Ports:
clk_in  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
start  in  1  pulse: begin a round using load_secs (restarts from any state)
stop  in  1  pulse: player answered; freeze the countdown
pause  in  1  pulse: toggle RUN <-> PAUSE
load_secs  in  SEC_W  round length, sampled only on the start cycle
secs_left  out  SEC_W  seconds remaining
tick  out  1  registered one-cycle pulse on each countdown decrement
running  out  1  high in RUN only
paused  out  1  high in PAUSE only
stopped  out  1  level: round ended by stop; held until the next start
expired  out  1  level: round reached 0; held until the next start

Behaviour:
- Interface: one clock, clk_in; reset is synchronous and active-high (rst).
- Reset (rst sampled high at an edge): state=IDLE, prescaler=0, secs_left=0. tick, running, paused, stopped and expired are all 0. rst overrides every input.
- States: IDLE, RUN, PAUSE, STOPPED, EXPIRED. running, paused, stopped and expired decode the state as registered outputs.
- Input priority in the same cycle: rst > start > stop > pause > internal tick.
- start, any state:
  - load_secs != 0: next state RUN, secs_left=load_secs, prescaler=0.
  - load_secs == 0: next state EXPIRED, secs_left=0, no tick.
- Prescaler counts 0..DIV-1, advances only in RUN and wraps to 0.
- Tick: on the edge where prescaler==DIV-1 in RUN, tick=1 for exactly that following cycle, and secs_left decrements at the same edge. The first tick is visible DIV cycles after the start edge.
- Timeout: a tick that takes secs_left from 1 to 0 moves RUN -> EXPIRED at the same edge. tick=1 and expired=1 appear together.
- pause: RUN -> PAUSE; PAUSE -> RUN. The prescaler holds its value, so the partial second is preserved. pause is ignored in IDLE, STOPPED and EXPIRED.
- stop: RUN or PAUSE -> STOPPED, secs_left frozen. In the same cycle as a terminal tick, stop wins: state STOPPED, secs_left unchanged, tick=0. stop is ignored in IDLE and EXPIRED.
- STOPPED and EXPIRED hold until start or rst.
- secs_left never underflows; it is only decremented when nonzero.
- rst mid-round aborts immediately, with no residual tick.

Decomposition:
- Package round_timer_pkg: state enum (IDLE, RUN, PAUSE, STOPPED, EXPIRED), function for DIV, and prescaler width = $clog2(DIV).
- Sub-module tick_prescaler: inputs clk_in, rst, clr, en; output wrap pulse; parameter DIV.
- round_timer_ctrl holds the FSM, the seconds counter and the output registers.

Test Plan:
1. CLK_HZ=10, TICK_HZ=1, start with load_secs=3 -> tick at cycles 10, 20, 30 after start; secs_left 2, 1, 0; expired=1 from cycle 30, running=0.
2. load_secs=5, pause at cycle 14, resume at cycle 40 -> secs_left stays 4 while paused; next tick at cycle 46 (6 remaining prescaler cycles); paused=1 only during the window.
3. load_secs=2, stop in the same cycle as the terminal tick (prescaler==9, secs_left=1) -> state STOPPED, secs_left=1, tick=0, expired=0.
4. start with load_secs=0 -> expired=1 next cycle, secs_left=0, no tick ever.
5. rst asserted at cycle 7 of a running round -> all outputs 0 at the next cycle; a start 3 cycles later runs normally and gives its first tick 10 cycles after start.
6. start asserted in EXPIRED with load_secs=4, together with stop and pause -> start wins: RUN, secs_left=4, stopped=0, expired=0.
